gf10_locator_eval: RTL and testbench
====================================

Name: gf10_locator_eval

Overview:
- Evaluates the error-locator polynomial sigma(x) = sigma_0 + sigma_1·x + … + sigma_T·x^T over GF(2^10) at a stream of points x = alpha^i.
- The points come from the gf10 counter stage.
- Uses Horner's method: one GF multiply-add per cycle.
- Sits directly downstream of the alpha counter in the Chien-search path. It reports per-point evaluation, root flag, point index and a running root count to the error-correction stage.

Parameters:
- GF_LEN, 10, field width. Only 10 is supported.
- T, 8, maximum locator degree. Legal range is 1..16.
- IDX_MAX, 1022, last point index (2^GF_LEN-2). The index wraps to 0 after this value.

Ports:
- clk  input  1  rising-edge clock
- in_ctr_Arstn  input  1  asynchronous active-low reset
- in_ctr_load  input  1  latch in_sigma. Also aborts any evaluation in progress.
- in_ctr_clear  input  1  synchronous clear of out_index and out_root_cnt
- in_sigma  input  (T+1)*GF_LEN  coefficients. sigma_k occupies bits [k*GF_LEN +: GF_LEN].
- in_alpha  input  GF_LEN  evaluation point, taken from the counter's out_alpha
- in_alpha_valid  input  1  evaluation point is valid
- out_alpha_ready  output  1  block accepts a point this cycle. Also drives the counter's in_ctr_en.
- out_eval  output  GF_LEN  sigma(in_alpha) for the current result
- out_root  output  1  out_eval == 0
- out_index  output  GF_LEN  index i of the current result
- out_valid  output  1  result valid
- in_out_ready  input  1  downstream accepts the result
- out_root_cnt  output  5  count of roots found since the last clear or load. Saturates at 31.

Behaviour:
- Reset (async assert, release synchronised by the user):
  - FSM = IDLE; coefficient registers = 0; acc = 0.
  - All outputs = 0, including out_alpha_ready and out_valid.
- FSM states:
  - IDLE: no coefficients held yet; out_alpha_ready = 0. in_ctr_load -> READY.
  - READY: out_alpha_ready = 1. A handshake (in_alpha_valid & out_alpha_ready) latches x = in_alpha, sets acc = sigma_T, sets k = T-1, and goes to CALC.
  - CALC: each cycle acc <= GF_Mult(acc, x) XOR sigma_k and k <= k-1. When the cycle with k == 0 completes -> DONE.
    - Multiplication uses the team's GF_Mult_2_10_comb (primitive polynomial x^10+x^3+1).
  - DONE: out_valid = 1, and out_eval/out_root/out_index are stable.
    - On in_out_ready, out_index increments at the same edge, wrapping IDX_MAX -> 0.
    - If out_root is set, out_root_cnt also increments at that edge, saturating at 31.
    - Then -> READY.
- Latency:
  - out_valid rises exactly T clock edges after the accept edge.
  - Throughput is one point per T+2 cycles with no backpressure. There is no overlap: out_alpha_ready = 0 in CALC and DONE.
- Backpressure: while out_valid & !in_out_ready, all outputs hold and no point is accepted.
- in_ctr_load is honoured in any non-reset state:
  - Latches in_sigma, clears acc, out_valid, out_index and out_root_cnt, and goes to READY.
  - A pending result is discarded without being counted.
- in_ctr_clear:
  - Zeroes out_index and out_root_cnt. FSM state and any pending result are unaffected.
  - If the clear coincides with a DONE handshake, the clear wins and both counters become 0.
- Simultaneous in_ctr_load and in_ctr_clear: load wins; the counters are zeroed either way.
- in_sigma is sampled only at load. Changes at other times are ignored.
- in_alpha is sampled only at accept. x is held internally through CALC.
- Reset asserted mid-CALC: the result is discarded and the block returns to IDLE; new coefficients must be loaded.

Test Plan:
- T=2; load sigma_0=1, sigma_1=1, sigma_2=0; present in_alpha=10'h001 -> out_valid exactly 2 edges after accept, out_eval=10'h000, out_root=1, out_index=0; after handshake out_root_cnt=1.
- Same coefficients; present in_alpha=10'h002 next -> out_eval=10'h003, out_root=0, out_index=1, out_root_cnt stays 1.
- Hold in_out_ready=0 for 5 cycles in DONE -> out_valid/out_eval constant, out_alpha_ready=0, no second point consumed; release -> index advances by exactly 1.
- Stream 1024 points with in_out_ready=1 -> out_index goes 1022 -> 0; out_root_cnt saturates at 31 when sigma is chosen with more roots (e.g., sigma=0 constant: every point is a root).
- Assert in_ctr_load one cycle into CALC -> no out_valid for that point, counters 0, out_alpha_ready=1 next cycle.
- Drop in_ctr_Arstn mid-CALC -> all outputs 0 immediately (async); after release out_alpha_ready stays 0 until a load.

Source files
------------

// File: rtl/gf10_locator_eval.sv
// Horner evaluation of the error-locator polynomial over GF(2^10) at one point per T+2 cycles.
// Result appears T edges after accept; a stalled result holds all outputs and blocks new points.
module gf10_locator_eval #(
    parameter int GF_LEN  = 10,
    parameter int T       = 8,
    parameter int IDX_MAX = 1022
) (
    input  logic                     clk,
    input  logic                     in_ctr_Arstn,
    input  logic                     in_ctr_load,
    input  logic                     in_ctr_clear,
    input  logic [(T+1)*GF_LEN-1:0]  in_sigma,
    input  logic [GF_LEN-1:0]        in_alpha,
    input  logic                     in_alpha_valid,
    output logic                     out_alpha_ready,
    output logic [GF_LEN-1:0]        out_eval,
    output logic                     out_root,
    output logic [GF_LEN-1:0]        out_index,
    output logic                     out_valid,
    input  logic                     in_out_ready,
    output logic [4:0]               out_root_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_CALC, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [(T+1)*GF_LEN-1:0]    r_sigma;
    logic [GF_LEN-1:0]          r_x;
    logic [GF_LEN-1:0]          r_acc;
    logic [4:0]                 r_k;
    logic [GF_LEN-1:0]          r_index;
    logic [4:0]                 r_cnt;
    logic                       w_accept;
    logic                       w_out_hs;
    logic [GF_LEN-1:0]          w_sigma_k;
    logic [GF_LEN-1:0]          w_mult;

    // Shift-and-add multiply, reducing by x^10 = x^3 + 1 as each partial product shifts up.
    function automatic logic [GF_LEN-1:0] gf_mult_2_10_comb(input logic [GF_LEN-1:0] a,
                                                            input logic [GF_LEN-1:0] b);
        logic [GF_LEN-1:0] p;
        logic [GF_LEN-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < GF_LEN; i++) begin
            if (b[i]) p = p ^ aa;
            if (aa[GF_LEN-1]) aa = {aa[GF_LEN-2:0], 1'b0} ^ GF_LEN'(10'h009);
            else              aa = {aa[GF_LEN-2:0], 1'b0};
        end
        return p;
    endfunction

    assign w_sigma_k = r_sigma[int'(r_k)*GF_LEN +: GF_LEN];
    assign w_mult    = gf_mult_2_10_comb(r_acc, r_x);
    assign w_accept  = (r_state == S_READY) && in_alpha_valid && !in_ctr_load;
    assign w_out_hs  = (r_state == S_DONE) && in_out_ready && !in_ctr_load;

    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (in_ctr_load) begin
            w_state_nxt = S_READY;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_READY: if (in_alpha_valid) w_state_nxt = S_CALC;
                S_CALC:  if (r_k == 5'd0)    w_state_nxt = S_DONE;
                S_DONE:  if (in_out_ready)   w_state_nxt = S_READY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn) begin
            r_sigma <= '0;
            r_x     <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_index <= '0;
            r_cnt   <= '0;
        end else if (in_ctr_load) begin
            r_sigma <= in_sigma;
            r_acc   <= '0;
            r_index <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= in_alpha;
                r_acc <= r_sigma[T*GF_LEN +: GF_LEN];
                r_k   <= 5'(T-1);
            end
            if (r_state == S_CALC) begin
                r_acc <= w_mult ^ w_sigma_k;
                r_k   <= r_k - 5'd1;
            end
            // Clear takes priority over a coincident result handshake.
            if (in_ctr_clear) begin
                r_index <= '0;
                r_cnt   <= '0;
            end else if (w_out_hs) begin
                r_index <= (r_index == GF_LEN'(IDX_MAX)) ? '0 : r_index + 1'b1;
                if ((r_acc == '0) && (r_cnt != 5'd31)) r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign out_alpha_ready = (r_state == S_READY);
    assign out_valid       = (r_state == S_DONE);
    assign out_eval        = r_acc;
    assign out_root        = (r_state == S_DONE) && (r_acc == '0);
    assign out_index       = r_index;
    assign out_root_cnt    = r_cnt;

endmodule

// File: tb/tb_gf10_locator_eval.sv
// Bench for gf10_locator_eval: directed T=2 sequence plus randomized T=8 points vs. a power-sum model.
module tb_gf10_locator_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_load, a_clear, a_avld, a_ordy;
    logic [29:0] a_sigma;
    logic [9:0]  a_alpha;
    logic        a_ardy, a_root, a_ovld;
    logic [9:0]  a_eval, a_index;
    logic [4:0]  a_cnt;

    logic        b_load, b_clear, b_avld, b_ordy;
    logic [89:0] b_sigma;
    logic [9:0]  b_alpha;
    logic        b_ardy, b_root, b_ovld;
    logic [9:0]  b_eval, b_index;
    logic [4:0]  b_cnt;

    int n_pass = 0;
    int n_tot  = 0;
    int m_idx, m_cnt, mb_idx, mb_cnt;
    logic [169:0] a_cur, b_cur;

    always #5 clk = ~clk;

    gf10_locator_eval #(.GF_LEN(10), .T(2), .IDX_MAX(1022)) u_a (
        .clk(clk), .in_ctr_Arstn(rst_n), .in_ctr_load(a_load), .in_ctr_clear(a_clear),
        .in_sigma(a_sigma), .in_alpha(a_alpha), .in_alpha_valid(a_avld),
        .out_alpha_ready(a_ardy), .out_eval(a_eval), .out_root(a_root), .out_index(a_index),
        .out_valid(a_ovld), .in_out_ready(a_ordy), .out_root_cnt(a_cnt));

    gf10_locator_eval #(.GF_LEN(10), .T(8), .IDX_MAX(1022)) u_b (
        .clk(clk), .in_ctr_Arstn(rst_n), .in_ctr_load(b_load), .in_ctr_clear(b_clear),
        .in_sigma(b_sigma), .in_alpha(b_alpha), .in_alpha_valid(b_avld),
        .out_alpha_ready(b_ardy), .out_eval(b_eval), .out_root(b_root), .out_index(b_index),
        .out_valid(b_ovld), .in_out_ready(b_ordy), .out_root_cnt(b_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full carry-less product, then polynomial long division by x^10+x^3+1.
    function automatic logic [9:0] ref_mul(input logic [9:0] a, input logic [9:0] b);
        logic [18:0] prod;
        prod = '0;
        for (int i = 0; i < 10; i++)
            if (b[i]) prod = prod ^ (19'(a) << i);
        for (int i = 18; i >= 10; i--)
            if (prod[i]) prod = prod ^ (19'h409 << (i - 10));
        return prod[9:0];
    endfunction

    // sigma(x) as a sum of sigma_k * x^k.
    function automatic logic [9:0] ref_eval(input logic [169:0] s, input int deg, input logic [9:0] x);
        logic [9:0] acc, xp;
        acc = '0;
        xp  = 10'd1;
        for (int k = 0; k <= deg; k++) begin
            acc = acc ^ ref_mul(s[k*10 +: 10], xp);
            xp  = ref_mul(xp, x);
        end
        return acc;
    endfunction

    task automatic a_do_load(input logic [29:0] s);
        a_load  = 1'b1;
        a_sigma = s;
        tick();
        a_load  = 1'b0;
        a_sigma = 30'(($urandom << 10) ^ $urandom);
        a_cur   = 170'(s);
        m_idx   = 0;
        m_cnt   = 0;
        chk("a_load_ardy", 32'(a_ardy), 1);
    endtask

    task automatic a_point(input logic [9:0] x);
        logic [9:0] e;
        int n;
        e = ref_eval(a_cur, 2, x);
        chk("a_ardy", 32'(a_ardy), 1);
        a_avld  = 1'b1;
        a_alpha = x;
        tick();
        a_avld  = 1'b0;
        a_alpha = 10'($urandom);
        n = 0;
        while (!a_ovld && n < 20) begin tick(); n++; end
        chk("a_latency", n, 2);
        chk("a_eval", 32'(a_eval), 32'(e));
        chk("a_root", 32'(a_root), 32'(e == 10'd0));
        chk("a_index", 32'(a_index), m_idx);
        a_ordy = 1'b1;
        tick();
        a_ordy = 1'b0;
        m_idx = (m_idx == 1022) ? 0 : m_idx + 1;
        if (e == 10'd0 && m_cnt < 31) m_cnt++;
        chk("a_cnt_after", 32'(a_cnt), m_cnt);
    endtask

    task automatic b_point(input logic [9:0] x);
        logic [9:0] e;
        int n;
        e = ref_eval(b_cur, 8, x);
        b_avld  = 1'b1;
        b_alpha = x;
        tick();
        b_avld  = 1'b0;
        n = 0;
        while (!b_ovld && n < 40) begin tick(); n++; end
        chk("b_latency", n, 8);
        chk("b_eval", 32'(b_eval), 32'(e));
        chk("b_root", 32'(b_root), 32'(e == 10'd0));
        chk("b_index", 32'(b_index), mb_idx);
        b_ordy = 1'b1;
        tick();
        b_ordy = 1'b0;
        mb_idx++;
        if (e == 10'd0 && mb_cnt < 31) mb_cnt++;
        chk("b_cnt", 32'(b_cnt), mb_cnt);
    endtask

    initial begin
        logic [9:0] x, s1, s2, hold;
        int n;
        rst_n = 1'b0;
        a_load = 0; a_clear = 0; a_avld = 0; a_ordy = 0; a_sigma = '0; a_alpha = '0;
        b_load = 0; b_clear = 0; b_avld = 0; b_ordy = 0; b_sigma = '0; b_alpha = '0;
        m_idx = 0; m_cnt = 0; mb_idx = 0; mb_cnt = 0; a_cur = '0; b_cur = '0;
        repeat (3) tick();
        chk("rst_ardy", 32'(a_ardy), 0);
        chk("rst_ovld", 32'(a_ovld), 0);
        chk("rst_eval", 32'(a_eval), 0);
        chk("rst_root", 32'(a_root), 0);
        chk("rst_index", 32'(a_index), 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        rst_n = 1'b1;
        a_avld = 1'b1;
        repeat (3) tick();
        a_avld = 1'b0;
        chk("idle_no_ardy", 32'(a_ardy), 0);
        chk("idle_no_ovld", 32'(a_ovld), 0);

        // sigma(x) = 1 + x
        a_do_load({10'd0, 10'd1, 10'd1});
        a_point(10'h001);
        chk("tp1_cnt", 32'(a_cnt), 1);
        a_point(10'h002);
        chk("tp2_cnt", 32'(a_cnt), 1);
        chk("tp2_idx", 32'(a_index), 2);

        // Backpressure: a second point waits on the input the whole time.
        a_avld  = 1'b1;
        a_alpha = 10'h004;
        tick();
        a_alpha = 10'h3ff;
        n = 0;
        while (!a_ovld && n < 20) begin tick(); n++; end
        chk("bp_latency", n, 2);
        hold = ref_eval(a_cur, 2, 10'h004);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ovld", 32'(a_ovld), 1);
            chk("bp_eval", 32'(a_eval), 32'(hold));
            chk("bp_ardy", 32'(a_ardy), 0);
        end
        a_ordy = 1'b1;
        tick();
        a_ordy = 1'b0;
        a_avld = 1'b0;
        chk("bp_idx_step", 32'(a_index), 3);
        tick();
        chk("bp_no_second", 32'(a_ovld), 0);
        chk("bp_ardy_back", 32'(a_ardy), 1);

        // Random coefficients, half of them forced to have x as a root.
        for (int r = 0; r < 12; r++) begin
            x  = 10'($urandom);
            s1 = 10'($urandom);
            s2 = 10'($urandom);
            if (r[0]) a_do_load({s2, s1, ref_mul(s1, x) ^ ref_mul(s2, ref_mul(x, x))});
            else      a_do_load({s2, s1, 10'($urandom)});
            a_point(x);
            a_point(10'($urandom));
        end

        // Clear during a pending result, then clear coinciding with the handshake.
        a_do_load({10'd0, 10'd1, 10'd1});
        a_point(10'h001);
        a_avld = 1'b1; a_alpha = 10'h001;
        tick();
        a_avld = 1'b0;
        repeat (2) tick();
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("clr_pending_ovld", 32'(a_ovld), 1);
        chk("clr_pending_idx", 32'(a_index), 0);
        chk("clr_pending_cnt", 32'(a_cnt), 0);
        a_clear = 1'b1; a_ordy = 1'b1;
        tick();
        a_clear = 1'b0; a_ordy = 1'b0;
        chk("clr_hs_idx", 32'(a_index), 0);
        chk("clr_hs_cnt", 32'(a_cnt), 0);
        chk("clr_hs_ardy", 32'(a_ardy), 1);

        // sigma = 0: every point is a root; index wraps and count saturates.
        a_do_load(30'd0);
        for (int p = 0; p < 1024; p++) a_point(10'($urandom));
        chk("wrap_idx", 32'(a_index), 1);
        chk("sat_cnt", 32'(a_cnt), 31);

        // Load one cycle into CALC aborts the point.
        a_avld = 1'b1; a_alpha = 10'h005;
        tick();
        a_avld = 1'b0;
        a_load = 1'b1; a_sigma = {10'd0, 10'd1, 10'd1};
        tick();
        a_load = 1'b0;
        chk("abort_ardy", 32'(a_ardy), 1);
        chk("abort_ovld", 32'(a_ovld), 0);
        chk("abort_idx", 32'(a_index), 0);
        chk("abort_cnt", 32'(a_cnt), 0);
        repeat (4) tick();
        chk("abort_still_no_ovld", 32'(a_ovld), 0);
        a_cur = 170'({10'd0, 10'd1, 10'd1});
        m_idx = 0; m_cnt = 0;
        a_point(10'h001);

        // T=8 instance with random coefficients.
        for (int k = 0; k < 9; k++) b_sigma[k*10 +: 10] = 10'($urandom);
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
        b_cur = 170'(b_sigma);
        b_sigma = '0;
        for (int p = 0; p < 20; p++) b_point(10'($urandom));

        // Reset mid-CALC.
        a_avld = 1'b1; a_alpha = 10'h002;
        tick();
        a_avld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ardy", 32'(a_ardy), 0);
        chk("arst_ovld", 32'(a_ovld), 0);
        chk("arst_eval", 32'(a_eval), 0);
        chk("arst_root", 32'(a_root), 0);
        chk("arst_idx", 32'(a_index), 0);
        chk("arst_cnt", 32'(a_cnt), 0);
        tick();
        rst_n = 1'b1;
        a_avld = 1'b1;
        repeat (4) tick();
        a_avld = 1'b0;
        chk("arst_idle_ardy", 32'(a_ardy), 0);
        chk("arst_idle_ovld", 32'(a_ovld), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
